// File: rtl/mult_ctrl.sv
// Shift-add multiplier sequencer: LOAD, then TEST/[ADD]/SHIFT per multiplier bit, then a DONE pulse.
// Optional abort input is enabled by defining MULT_CTRL_ABORT_EN.
module mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
`ifdef MULT_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic load_registers,
  output logic add,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        cnt_nxt   = '0;
        state_nxt = S_TEST;
      end
      S_TEST:  state_nxt = q0 ? S_ADD : S_SHIFT;
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        cnt_nxt   = cnt + CW'(1);
        state_nxt = (cnt == CW'(WIDTH - 1)) ? S_DONE : S_TEST;
      end
      S_DONE: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
`ifdef MULT_CTRL_ABORT_EN
    // Abort is honoured only mid-operation; DONE always completes its pulse.
    if (abort && state != S_IDLE && state != S_DONE) begin
      cnt_nxt   = '0;
      state_nxt = S_IDLE;
    end
`endif
  end

  // Outputs are decoded from the next state so they flop alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      load_registers <= 1'b0;
      add            <= 1'b0;
      shift          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      load_registers <= (state_nxt == S_LOAD);
      add            <= (state_nxt == S_ADD);
      shift          <= (state_nxt == S_SHIFT);
      busy           <= (state_nxt != S_IDLE);
      done           <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: a behavioural A/B/Q bank closes the q0 loop; expected strobes come from the per-bit cost rules.
module tb_mult_ctrl;
  localparam int WIDTH = 8;

  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_LOAD  = 5'b10010;
  localparam logic [4:0] C_TEST  = 5'b00010;
  localparam logic [4:0] C_ADD   = 5'b01010;
  localparam logic [4:0] C_SHIFT = 5'b00110;
  localparam logic [4:0] C_DONE  = 5'b00011;

  logic clk;
  logic rst;
  logic start;
  logic q0;
`ifdef MULT_CTRL_ABORT_EN
  logic abort;
`endif
  logic load_registers;
  logic add;
  logic shift;
  logic busy;
  logic done;

  logic [WIDTH-1:0] xin;
  logic [WIDTH-1:0] yin;
  logic [WIDTH-1:0] bank_a;
  logic [WIDTH-1:0] bank_b;
  logic [WIDTH-1:0] bank_q;
  logic             bank_c;
  logic [WIDTH-1:0] rx;
  logic [WIDTH-1:0] ry;
  logic [4:0]       outs;
  int               total;
  int               bad;
  int               n;

  mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .q0             (q0),
`ifdef MULT_CTRL_ABORT_EN
    .abort          (abort),
`endif
    .load_registers (load_registers),
    .add            (add),
    .shift          (shift),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign outs = {load_registers, add, shift, busy, done};
  assign q0   = bank_q[0];

  // Register bank behaviour as seen by the controller.
  always @(posedge clk) begin
    if (load_registers) begin
      bank_b <= xin;
      bank_q <= yin;
      bank_a <= '0;
      bank_c <= 1'b0;
    end else if (add) begin
      {bank_c, bank_a} <= {1'b0, bank_a} + {1'b0, bank_b};
    end else if (shift) begin
      {bank_c, bank_a, bank_q} <= {1'b0, bank_c, bank_a, bank_q[WIDTH-1:1]};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation; p1/p2 are cycle offsets after the start edge at which start is re-pulsed.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input int p1, input int p2, input string tag);
    logic [4:0] seq[$];
    int ndone;
    int dcyc;
    ndone = 0;
    dcyc  = -1;
    seq.push_back(C_LOAD);
    for (int i = 0; i < WIDTH; i++) begin
      seq.push_back(C_TEST);
      if (y[i]) seq.push_back(C_ADD);
      seq.push_back(C_SHIFT);
    end
    seq.push_back(C_DONE);
    seq.push_back(C_IDLE);
    xin   = x;
    yin   = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= seq.size(); c++) begin
      chk({tag, "/strobes"}, 64'(outs), 64'(seq[c-1]));
      if (done) begin
        ndone++;
        dcyc = c;
      end
      start = (c == p1) || (c == p2);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "/done_count"}, 64'(ndone), 64'd1);
    chk({tag, "/done_cycle"}, 64'(dcyc), 64'(2 + 2 * WIDTH + $countones(y)));
    chk({tag, "/product"}, 64'({bank_a, bank_q}), 64'(x) * 64'(y));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    xin   = '0;
    yin   = '0;
`ifdef MULT_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    chk("reset/outs", 64'(outs), 64'(C_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset/release", 64'(outs), 64'(C_IDLE));
    @(negedge clk);
    chk("reset/idle", 64'(outs), 64'(C_IDLE));

    rx = WIDTH'($urandom);
    run_op(rx, 8'h00, -1, -1, "y00");
    rx = WIDTH'($urandom);
    run_op(rx, 8'hFF, -1, -1, "yff");
    run_op(8'h03, 8'hA5, -1, -1, "ya5");
    chk("ya5/bank_product", 64'({bank_a, bank_q}), 64'h01EF);

    rx = WIDTH'($urandom);
    ry = WIDTH'($urandom);
    run_op(rx, ry, 3, 10, "restart");

    for (int i = 0; i < 6; i++) begin
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      run_op(rx, ry, -1, -1, "random");
    end

    // start held high through DONE: one IDLE cycle, then a new LOAD.
    rx    = WIDTH'($urandom);
    ry    = WIDTH'($urandom);
    xin   = rx;
    yin   = ry;
    start = 1'b1;
    n     = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold/done_seen", 64'(done), 64'd1);
    chk("hold/latency", 64'(n), 64'(2 + 2 * WIDTH + $countones(ry)));
    @(negedge clk);
    chk("hold/idle_gap", 64'(outs), 64'(C_IDLE));
    @(negedge clk);
    chk("hold/reload", 64'(outs), 64'(C_LOAD));
    start = 1'b0;
    n     = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold/second_done", 64'(done), 64'd1);
    chk("hold/product", 64'({bank_a, bank_q}), 64'(rx) * 64'(ry));
    @(negedge clk);

    // Asynchronous reset in cycle k+7.
    xin   = WIDTH'($urandom);
    yin   = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid/busy_before", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid/async_outs", 64'(outs), 64'(C_IDLE));
    @(negedge clk);
    chk("rst_mid/held", 64'(outs), 64'(C_IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid/idle", 64'(outs), 64'(C_IDLE));
    rx = WIDTH'($urandom);
    ry = WIDTH'($urandom);
    run_op(rx, ry, -1, -1, "after_rst");

`ifdef MULT_CTRL_ABORT_EN
    // Abort sampled at the end of cycle k+9.
    xin   = WIDTH'($urandom);
    yin   = WIDTH'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort/busy_before", 64'(busy), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort/idle", 64'(outs), 64'(C_IDLE));
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("abort/no_done", 64'(n), 64'd0);
    rx = WIDTH'($urandom);
    ry = WIDTH'($urandom);
    run_op(rx, ry, -1, -1, "after_abort");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
